cdb_arbiter: RTL and testbench
==============================

CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
Parameters (name, default, meaning):
REQ-001 NUM_FU, 4: number of functional units requesting the CDB.
REQ-002 ROB_ADDR_LEN, 4: ROB tag width (ROB_SIZE = 16).
REQ-003 XLEN, 32: result data width.

Ports (name, direction, width, meaning):
REQ-004 clk  input  1  clock; all state updates on posedge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 fu_req  input  NUM_FU  per-FU request to broadcast one completed result.
REQ-007 fu_rob_tag  input  NUM_FU*ROB_ADDR_LEN  per-FU ROB tag; FU i occupies bits [i*ROB_ADDR_LEN +: ROB_ADDR_LEN].
REQ-008 fu_result  input  NUM_FU*XLEN  per-FU result; FU i occupies bits [i*XLEN +: XLEN].
REQ-009 flush  input  1  pipeline flush (branch mispredict); squashes the broadcast in progress.
REQ-010 fu_grant  output  NUM_FU  one-hot-or-zero grant, combinational in the same cycle as the request.
REQ-011 cdb_valid  output  1  registered CDB broadcast valid; drives the ROB cdb_to_rob input.
REQ-012 cdb_rob_tag  output  ROB_ADDR_LEN  registered broadcast tag; drives the ROB rob_tag_from_cdb input.
REQ-013 cdb_result  output  XLEN  registered broadcast data; drives the ROB cdb_result input.

Function
REQ-014 The block SHALL hold a round-robin priority pointer ptr (log2(NUM_FU) bits) and one output register (valid, tag, result).
REQ-015 Each cycle it SHALL grant the first FU i with fu_req[i]=1, scanning ptr, ptr+1, ... modulo NUM_FU; at most one fu_grant bit SHALL be 1.
REQ-016 fu_grant SHALL be all-zero when fu_req is all-zero, when flush=1 or when reset=1.
REQ-017 A request SHALL be complete in the cycle its grant is 1; an FU SHALL hold fu_req and payload stable until granted, and may deassert without being granted.
REQ-018 On a grant to FU g, the next posedge SHALL load cdb_valid=1, cdb_rob_tag=fu_rob_tag[g], cdb_result=fu_result[g]; latency from request to CDB = 1 cycle.
REQ-019 On a grant to FU g, ptr SHALL become (g+1) mod NUM_FU; ptr wraps from NUM_FU-1 to 0.
REQ-020 With no grant, the next posedge SHALL load cdb_valid=0; ptr and cdb_rob_tag/cdb_result SHALL hold their values.
REQ-021 cdb_valid SHALL be 1 for exactly one cycle per grant; back-to-back grants SHALL give consecutive valid cycles with no bubble.
REQ-022 With flush=1, the next posedge SHALL load cdb_valid=0 and leave ptr unchanged; a broadcast already registered and visible in the flush cycle is not retracted.
REQ-023 Fairness: a request held continuously SHALL be granted within NUM_FU cycles while flush=0.
REQ-024 All FUs requesting SHALL yield grants in rotating order ptr, ptr+1, ... with one grant per cycle.

Reset
REQ-025 With reset=1 at posedge, the next state SHALL be ptr=0, cdb_valid=0, cdb_rob_tag=0, cdb_result=0.
REQ-026 reset SHALL take priority over flush and over all requests; a grant combinationally visible in the reset cycle SHALL be suppressed (fu_grant=0).
REQ-027 Reset applied mid-stream SHALL discard the pending broadcast; the first grant after reset SHALL use ptr=0.

Verification
REQ-028 After reset, fu_req=4'b0100, tag[2]=5, result[2]=32'hDEAD_BEEF -> fu_grant=4'b0100 in the same cycle; next cycle cdb_valid=1, tag=5, data=32'hDEAD_BEEF, ptr=3.
REQ-029 fu_req=4'b1111 held for 5 cycles from ptr=0 -> grants FU0, FU1, FU2, FU3, FU0; cdb_valid=1 on 5 consecutive cycles.
REQ-030 ptr=3, fu_req=4'b1001 -> grant FU3, then FU0 (wrap), then FU3 again with FU0 still requesting.
REQ-031 fu_req=4'b0010 with flush=1 -> fu_grant=0; next cycle cdb_valid=0, ptr unchanged; FU1 granted the cycle after flush drops.
REQ-032 Reset asserted in a cycle with fu_req=4'b1000 and ptr=2 -> fu_grant=0; next cycle cdb_valid=0, ptr=0, tag=0, data=0.
REQ-033 fu_req=0 for 3 cycles after a grant -> cdb_valid=0 on each cycle, tag/data and ptr held.

Source files
------------

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: picks one completing functional unit per cycle
// with a rotating (round-robin) priority. The winner's ROB tag and result
// are registered onto the CDB one cycle after the grant.
module cdb_arbiter #(
    parameter int NUM_FU       = 4,
    parameter int ROB_ADDR_LEN = 4,
    parameter int XLEN         = 32
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_FU-1:0]              fu_req,
    input  logic [NUM_FU*ROB_ADDR_LEN-1:0] fu_rob_tag,
    input  logic [NUM_FU*XLEN-1:0]         fu_result,
    input  logic                           flush,
    output logic [NUM_FU-1:0]              fu_grant,
    output logic                           cdb_valid,
    output logic [ROB_ADDR_LEN-1:0]        cdb_rob_tag,
    output logic [XLEN-1:0]                cdb_result
);

    localparam int PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

    logic [PTR_W-1:0]        ptr_reg;
    logic [PTR_W-1:0]        ptr_next;
    logic                    cdb_valid_reg;
    logic [ROB_ADDR_LEN-1:0] cdb_tag_reg;
    logic [ROB_ADDR_LEN-1:0] cdb_tag_next;
    logic [XLEN-1:0]         cdb_result_reg;
    logic [XLEN-1:0]         cdb_result_next;

    logic                    grant_found;
    logic [PTR_W-1:0]        grant_idx;
    logic                    grant_ok;

    logic [ROB_ADDR_LEN-1:0] tag_arr    [NUM_FU];
    logic [XLEN-1:0]         result_arr [NUM_FU];

    // Unpack the flat per-FU payload buses into indexable arrays.
    generate
        for (genvar gi = 0; gi < NUM_FU; gi++) begin : g_unpack
            assign tag_arr[gi]    = fu_rob_tag[gi*ROB_ADDR_LEN +: ROB_ADDR_LEN];
            assign result_arr[gi] = fu_result[gi*XLEN +: XLEN];
        end
    endgenerate

    // Scan requesters starting at the priority pointer, wrapping modulo NUM_FU.
    always_comb begin
        logic [PTR_W:0]   sum;
        logic [PTR_W-1:0] scan_idx;
        grant_found = 1'b0;
        grant_idx   = '0;
        sum         = '0;
        scan_idx    = '0;
        for (int k = 0; k < NUM_FU; k++) begin
            sum = {1'b0, ptr_reg} + (PTR_W+1)'(k);
            if (sum >= (PTR_W+1)'(NUM_FU)) begin
                sum = sum - (PTR_W+1)'(NUM_FU);
            end
            scan_idx = sum[PTR_W-1:0];
            if (!grant_found && fu_req[scan_idx]) begin
                grant_found = 1'b1;
                grant_idx   = scan_idx;
            end
        end
    end

    // Reset and flush both veto the grant; the vetoed request simply waits.
    assign grant_ok = grant_found & ~flush & ~reset;

    // One-hot grant decode, visible in the same cycle as the request.
    always_comb begin
        fu_grant = '0;
        if (grant_ok) begin
            fu_grant[grant_idx] = 1'b1;
        end
    end

    // Next pointer and broadcast payload; everything holds when nobody wins.
    always_comb begin
        ptr_next        = ptr_reg;
        cdb_tag_next    = cdb_tag_reg;
        cdb_result_next = cdb_result_reg;
        if (grant_ok) begin
            ptr_next        = (grant_idx == PTR_W'(NUM_FU - 1)) ? '0 : grant_idx + 1'b1;
            cdb_tag_next    = tag_arr[grant_idx];
            cdb_result_next = result_arr[grant_idx];
        end
    end

    // Priority pointer and CDB output register.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_reg        <= '0;
            cdb_valid_reg  <= 1'b0;
            cdb_tag_reg    <= '0;
            cdb_result_reg <= '0;
        end else begin
            ptr_reg        <= ptr_next;
            cdb_valid_reg  <= grant_ok;
            cdb_tag_reg    <= cdb_tag_next;
            cdb_result_reg <= cdb_result_next;
        end
    end

    assign cdb_valid   = cdb_valid_reg;
    assign cdb_rob_tag = cdb_tag_reg;
    assign cdb_result  = cdb_result_reg;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: a driver issues per-cycle stimulus and
// pushes expected grant / CDB values from a reference model; a monitor pops
// and compares them on the falling edge.
module tb_cdb_arbiter;

    localparam int NUM_FU = 4;
    localparam int RW     = 4;
    localparam int XLEN   = 32;

    typedef struct packed {
        logic            valid;
        logic [RW-1:0]   tag;
        logic [XLEN-1:0] result;
    } cdb_t;

    logic                   clk;
    logic                   reset;
    logic [NUM_FU-1:0]      fu_req;
    logic [NUM_FU*RW-1:0]   fu_rob_tag;
    logic [NUM_FU*XLEN-1:0] fu_result;
    logic                   flush;
    logic [NUM_FU-1:0]      fu_grant;
    logic                   cdb_valid;
    logic [RW-1:0]          cdb_rob_tag;
    logic [XLEN-1:0]        cdb_result;

    int total = 0;
    int bad   = 0;

    logic [NUM_FU-1:0] grant_q [$];
    cdb_t              cdb_q   [$];

    // Reference model state
    int              m_ptr;
    cdb_t            m_cdb;
    logic [RW-1:0]   tag_v [NUM_FU];
    logic [XLEN-1:0] res_v [NUM_FU];

    cdb_arbiter #(.NUM_FU(NUM_FU), .ROB_ADDR_LEN(RW), .XLEN(XLEN)) dut (
        .clk        (clk),
        .reset      (reset),
        .fu_req     (fu_req),
        .fu_rob_tag (fu_rob_tag),
        .fu_result  (fu_result),
        .flush      (flush),
        .fu_grant   (fu_grant),
        .cdb_valid  (cdb_valid),
        .cdb_rob_tag(cdb_rob_tag),
        .cdb_result (cdb_result)
    );

    // Clock starts high so the first falling edge precedes the first rising edge.
    initial clk = 1'b1;
    always #5 clk = ~clk;

    // Apply one cycle of stimulus and record what the model expects.
    task automatic drive_cycle(input logic [NUM_FU-1:0] req, input logic fl, input logic rs);
        int               winner;
        logic [NUM_FU-1:0] exp_g;
        fu_req = req;
        flush  = fl;
        reset  = rs;
        for (int i = 0; i < NUM_FU; i++) begin
            fu_rob_tag[i*RW +: RW]     = tag_v[i];
            fu_result[i*XLEN +: XLEN]  = res_v[i];
        end
        winner = -1;
        if (!rs && !fl) begin
            for (int k = 0; k < NUM_FU; k++) begin
                if (winner < 0 && req[(m_ptr + k) % NUM_FU]) winner = (m_ptr + k) % NUM_FU;
            end
        end
        exp_g = '0;
        if (winner >= 0) exp_g[winner] = 1'b1;
        grant_q.push_back(exp_g);
        if (rs) begin
            m_ptr = 0;
            m_cdb = '0;
        end else if (winner >= 0) begin
            m_cdb.valid  = 1'b1;
            m_cdb.tag    = tag_v[winner];
            m_cdb.result = res_v[winner];
            m_ptr        = (winner + 1) % NUM_FU;
        end else begin
            m_cdb.valid = 1'b0;
        end
        cdb_q.push_back(m_cdb);
        @(posedge clk);
        #1;
    endtask

    task automatic randomize_payloads();
        for (int i = 0; i < NUM_FU; i++) begin
            tag_v[i] = RW'($urandom);
            res_v[i] = $urandom;
        end
    endtask

    // Monitor: compare the same-cycle grant, and the CDB register loaded by
    // the previous cycle's stimulus.
    initial begin
        logic [NUM_FU-1:0] eg;
        cdb_t              ec;
        forever begin
            @(negedge clk);
            if (grant_q.size() > 0) begin
                eg = grant_q.pop_front();
                total++;
                if (fu_grant !== eg) begin
                    bad++;
                    $display("FAIL grant t=%0t got=%b want=%b", $time, fu_grant, eg);
                end
            end
            if (cdb_q.size() >= 2) begin
                ec = cdb_q.pop_front();
                total++;
                if (cdb_valid !== ec.valid || cdb_rob_tag !== ec.tag || cdb_result !== ec.result) begin
                    bad++;
                    $display("FAIL cdb t=%0t got v=%b tag=%0d res=%h want v=%b tag=%0d res=%h",
                             $time, cdb_valid, cdb_rob_tag, cdb_result, ec.valid, ec.tag, ec.result);
                end else if (ec.valid) begin
                    $display("cdb t=%0t tag=%0d res=%h ok", $time, ec.tag, ec.result);
                end
            end
        end
    end

    // Driver: directed scenarios followed by randomized traffic.
    initial begin
        m_ptr = 0;
        m_cdb = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            tag_v[i] = RW'(i + 8);
            res_v[i] = 32'h1000_0000 + i;
        end
        drive_cycle(4'b0000, 1'b0, 1'b1);
        drive_cycle(4'b0000, 1'b0, 1'b1);

        // Single request from FU2; afterwards the pointer sits at 3.
        tag_v[2] = 4'd5;
        res_v[2] = 32'hDEAD_BEEF;
        drive_cycle(4'b0100, 1'b0, 1'b0);
        // Pointer at 3 with FU3 and FU0 requesting: 3, 0 (wrap), 3.
        drive_cycle(4'b1001, 1'b0, 1'b0);
        drive_cycle(4'b1001, 1'b0, 1'b0);
        drive_cycle(4'b1001, 1'b0, 1'b0);
        // Everyone requesting from pointer 0 for five cycles.
        for (int c = 0; c < 5; c++) drive_cycle(4'b1111, 1'b0, 1'b0);
        // Idle: valid drops, payload holds.
        for (int c = 0; c < 3; c++) drive_cycle(4'b0000, 1'b0, 1'b0);
        // Flush vetoes FU1, which wins once flush drops.
        drive_cycle(4'b0010, 1'b1, 1'b0);
        drive_cycle(4'b0010, 1'b0, 1'b0);
        // Reset with pointer at 2 and FU3 requesting.
        drive_cycle(4'b1000, 1'b0, 1'b1);
        drive_cycle(4'b0000, 1'b0, 1'b0);
        // First grant after reset uses pointer 0.
        drive_cycle(4'b1010, 1'b0, 1'b0);

        for (int c = 0; c < 400; c++) begin
            randomize_payloads();
            drive_cycle(NUM_FU'($urandom),
                        ($urandom_range(0, 7) == 0),
                        ($urandom_range(0, 49) == 0));
        end
        drive_cycle(4'b0000, 1'b0, 1'b0);
        drive_cycle(4'b0000, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        total++;
        if (grant_q.size() != 0 || cdb_q.size() > 1) begin
            bad++;
            $display("FAIL drain got grant_q=%0d cdb_q=%0d want 0 and <=1", grant_q.size(), cdb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
